// File: rtl/jt1943_prog_sdram.sv
`default_nettype none
// ============================================================================
//  Module   : jt1943_prog_sdram
//  Purpose  : Turns ROM-download byte writes into 16-bit SDRAM write requests
//             with a req/ack handshake. A small FIFO absorbs SDRAM latency
//             because the download side cannot be stalled.
//  Options  : JT1943_PROG_MERGE_EN - merge complementary byte writes to the
//             same word address into one full-word SDRAM write.
//  Revision : 1.0 - initial release
// ============================================================================
module jt1943_prog_sdram #(
  parameter int FIFO_AW = 3,
  parameter int AW      = 22
) (
  input  logic          clk_rom,
  input  logic          rst,
  input  logic          downloading,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [1:0]    prog_mask,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_wrmask,
  input  logic          sdram_ack,
  output logic          dl_busy,
  output logic          overflow
);

  // FIFO entry layout: {word address, 16-bit data, active-low lane mask}
  localparam int c_DEPTH = 2**FIFO_AW;
  localparam int c_EW    = AW + 18;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_REQ  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;
  logic [c_EW-1:0]  r_mem [c_DEPTH];
  logic [c_EW-1:0]  w_head;
  logic [c_EW-1:0]  w_push_ent;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_load;
  logic             w_push_req;
  logic             w_push;
  logic             w_wr_valid;
  logic             w_hold_busy;

  // A write with both lanes masked targets PROM only and never reaches SDRAM
  assign w_wr_valid = prog_we && (prog_mask != 2'b11);

`ifdef JT1943_PROG_MERGE_EN
  logic          r_hold_vld;
  logic [AW-1:0] r_hold_addr;
  logic [15:0]   r_hold_din;
  logic [1:0]    r_hold_mask;
  logic          w_merge;

  assign w_merge = r_hold_vld && w_wr_valid && (prog_addr == r_hold_addr) &&
                   (((r_hold_mask == 2'b10) && (prog_mask == 2'b01)) ||
                    ((r_hold_mask == 2'b01) && (prog_mask == 2'b10)));

  // Choose what enters the FIFO: a merged word, or the displaced/flushed held entry
  always_comb begin
    w_push_req = 1'b0;
    w_push_ent = {r_hold_addr, r_hold_din, r_hold_mask};
    if (w_merge) begin
      w_push_req = 1'b1;
      w_push_ent = {r_hold_addr,
                    (r_hold_mask[1] ? prog_data : r_hold_din[15:8]),
                    (r_hold_mask[0] ? prog_data : r_hold_din[7:0]),
                    2'b00};
    end else if (w_wr_valid) begin
      w_push_req = r_hold_vld;
    end else if (!downloading) begin
      // Once the download is over nothing can complete the held word
      w_push_req = r_hold_vld;
    end
  end

  // One-entry merge register holding the most recent unpaired byte write
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      r_hold_vld  <= 1'b0;
      r_hold_addr <= '0;
      r_hold_din  <= '0;
      r_hold_mask <= 2'b11;
    end else if (w_merge) begin
      r_hold_vld  <= 1'b0;
    end else if (w_wr_valid) begin
      r_hold_vld  <= 1'b1;
      r_hold_addr <= prog_addr;
      r_hold_din  <= {prog_data, prog_data};
      r_hold_mask <= prog_mask;
    end else if (!downloading) begin
      r_hold_vld  <= 1'b0;
    end
  end

  assign w_hold_busy = r_hold_vld;
`else
  logic w_unused_dl;

  assign w_push_req  = w_wr_valid;
  assign w_push_ent  = {prog_addr, prog_data, prog_data, prog_mask};
  assign w_hold_busy = 1'b0;
  assign w_unused_dl = downloading;
`endif

  // Extra MSB on each pointer distinguishes full from empty
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  // FIFO storage; the head is already copied to the outputs before it can be overwritten
  always_ff @(posedge clk_rom) begin
    if (w_push) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_push_ent;
    end
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_req && !w_push) begin
        overflow <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: issue when data is queued, return to idle on ack
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (!w_empty)  w_state_nxt = c_ST_REQ;
      c_ST_REQ:  if (sdram_ack) w_state_nxt = c_ST_IDLE;
      default:                  w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM outputs: head load strobe, pop on ack, request level
  always_comb begin
    w_load    = 1'b0;
    w_pop     = 1'b0;
    sdram_req = 1'b0;
    case (r_state)
      c_ST_IDLE: w_load = !w_empty;
      c_ST_REQ: begin
        sdram_req = 1'b1;
        w_pop     = sdram_ack;
      end
      default: ;
    endcase
  end

  // Request payload registers stay stable for the whole request
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      sdram_addr   <= '0;
      sdram_din    <= '0;
      sdram_wrmask <= 2'b11;
    end else if (w_load) begin
      sdram_addr   <= w_head[c_EW-1:18];
      sdram_din    <= w_head[17:2];
      sdram_wrmask <= w_head[1:0];
    end
  end

  assign dl_busy = !w_empty || (r_state == c_ST_REQ) || w_hold_busy;

endmodule
`default_nettype wire

// File: tb/tb_jt1943_prog_sdram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt1943_prog_sdram
//  Purpose  : Directed self-checking bench for jt1943_prog_sdram with a
//             scoreboard of expected SDRAM writes and an acking responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jt1943_prog_sdram;

  localparam int AW = 22;
`ifdef JT1943_PROG_MERGE_EN
  // A lone write sits in the merge register for one cycle before it is queued
  localparam int c_LAT = 3;
`else
  localparam int c_LAT = 2;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
    logic [1:0]    m;
  } ent_t;

  logic          clk_rom     = 1'b0;
  logic          rst         = 1'b1;
  logic          downloading = 1'b0;
  logic          prog_we     = 1'b0;
  logic [AW-1:0] prog_addr   = '0;
  logic [7:0]    prog_data   = '0;
  logic [1:0]    prog_mask   = 2'b11;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic [15:0]   sdram_din;
  logic [1:0]    sdram_wrmask;
  logic          sdram_ack   = 1'b0;
  logic          dl_busy;
  logic          overflow;

  ent_t sb[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   ack_cnt  = 0;
  int   ack_dly  = 0;
  int   wait_cnt = 0;
  bit   ack_en   = 1'b0;

  always #5 clk_rom = ~clk_rom;

  jt1943_prog_sdram #(.FIFO_AW(3), .AW(AW)) dut (
    .clk_rom      (clk_rom),
    .rst          (rst),
    .downloading  (downloading),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .prog_mask    (prog_mask),
    .sdram_req    (sdram_req),
    .sdram_addr   (sdram_addr),
    .sdram_din    (sdram_din),
    .sdram_wrmask (sdram_wrmask),
    .sdram_ack    (sdram_ack),
    .dl_busy      (dl_busy),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_rom);
      #1;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d, input logic [1:0] m);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    prog_mask = m;
    step();
    prog_we   = 1'b0;
    prog_mask = 2'b11;
  endtask

  // Responder: ack each request after ack_dly waiting cycles and check it against the scoreboard
  initial forever begin
    ent_t e;
    @(posedge clk_rom);
    #1;
    sdram_ack = 1'b0;
    if (rst) begin
      wait_cnt = 0;
    end else if (sdram_req && ack_en) begin
      if (wait_cnt >= ack_dly) begin
        n_cmp++;
        assert (sb.size() > 0) else begin
          n_err++;
          $error("FAIL unexpected_req: observed request addr %0h expected none", sdram_addr);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("wr_addr", sdram_addr, e.a);
          chk("wr_din", sdram_din, e.d);
          chk("wr_mask", sdram_wrmask, e.m);
        end
        sdram_ack = 1'b1;
        wait_cnt  = 0;
        ack_cnt++;
      end else begin
        wait_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    // Reset state
    step(3);
    chk("rst_req", sdram_req, 1'b0);
    chk("rst_addr", sdram_addr, '0);
    chk("rst_din", sdram_din, 16'h0000);
    chk("rst_mask", sdram_wrmask, 2'b11);
    chk("rst_busy", dl_busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    step();

    // 1: single write, latency and ack after 3 cycles
    ack_en  = 1'b1;
    ack_dly = 3;
    base    = ack_cnt;
    sb.push_back('{a: 22'h00010, d: 16'hA5A5, m: 2'b10});
    wr(22'h00010, 8'hA5, 2'b10);
    chk("t1_req_early", sdram_req, 1'b0);
    step(c_LAT - 1);
    chk("t1_req", sdram_req, 1'b1);
    chk("t1_addr", sdram_addr, 22'h00010);
    chk("t1_din", sdram_din, 16'hA5A5);
    chk("t1_mask", sdram_wrmask, 2'b10);
    step(3);
    chk("t1_req_hold", sdram_req, 1'b1);
    step();
    chk("t1_req_drop", sdram_req, 1'b0);
    chk("t1_acks", ack_cnt - base, 1);
    chk("t1_busy", dl_busy, 1'b0);

    // 2: nine writes into an 8-deep FIFO with ack held off
    ack_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sb.push_back('{a: 22'h100 + i, d: {2{8'(i + 1)}}, m: 2'b10});
      wr(22'h100 + i, 8'(i + 1), 2'b10);
      if (i == 7) chk("t2_ovf_before", overflow, 1'b0);
    end
    step();
    chk("t2_ovf", overflow, 1'b1);
    chk("t2_req", sdram_req, 1'b1);
    chk("t2_busy", dl_busy, 1'b1);
    base    = ack_cnt;
    ack_dly = 0;
    ack_en  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!dl_busy) break;
    end
    chk("t2_acks", ack_cnt - base, 8);
    chk("t2_req_end", sdram_req, 1'b0);
    chk("t2_ovf_sticky", overflow, 1'b1);

    // 3: PROM-only write is discarded
    rst = 1'b1;
    step();
    chk("t3_ovf_clr", overflow, 1'b0);
    rst  = 1'b0;
    base = ack_cnt;
    wr(22'h00020, 8'h55, 2'b11);
    for (int i = 0; i < 4; i++) begin
      chk("t3_req", sdram_req, 1'b0);
      chk("t3_busy", dl_busy, 1'b0);
      step();
    end
    chk("t3_acks", ack_cnt - base, 0);

    // 4: reset while a request is pending with entries queued
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{a: 22'h200 + i, d: {2{8'(8'h60 + i)}}, m: 2'b01});
      wr(22'h200 + i, 8'(8'h60 + i), 2'b01);
    end
    step();
    chk("t4_req_before", sdram_req, 1'b1);
    chk("t4_busy_before", dl_busy, 1'b1);
    rst = 1'b1;
    step();
    chk("t4_req", sdram_req, 1'b0);
    chk("t4_busy", dl_busy, 1'b0);
    chk("t4_addr", sdram_addr, '0);
    chk("t4_mask", sdram_wrmask, 2'b11);
    sb.delete();
    rst     = 1'b0;
    ack_en  = 1'b1;
    ack_dly = 0;
    base    = ack_cnt;
    step(12);
    chk("t4_req_after", sdram_req, 1'b0);
    chk("t4_busy_after", dl_busy, 1'b0);
    chk("t4_acks", ack_cnt - base, 0);

    // 5: complementary byte writes to one word
    downloading = 1'b1;
    ack_dly     = 1;
    base        = ack_cnt;
`ifdef JT1943_PROG_MERGE_EN
    sb.push_back('{a: 22'h5, d: 16'h3412, m: 2'b00});
`else
    sb.push_back('{a: 22'h5, d: 16'h1212, m: 2'b10});
    sb.push_back('{a: 22'h5, d: 16'h3434, m: 2'b01});
`endif
    wr(22'h5, 8'h12, 2'b10);
    wr(22'h5, 8'h34, 2'b01);
    downloading = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!dl_busy) break;
    end
`ifdef JT1943_PROG_MERGE_EN
    chk("t5_acks", ack_cnt - base, 1);
`else
    chk("t5_acks", ack_cnt - base, 2);
`endif

    // 6: downloading falls with three entries outstanding
    ack_en      = 1'b0;
    downloading = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{a: 22'h300 + i, d: {2{8'(8'h40 + i)}}, m: 2'b01});
      wr(22'h300 + i, 8'(8'h40 + i), 2'b01);
    end
    step(2);
    chk("t6_busy_dl", dl_busy, 1'b1);
    downloading = 1'b0;
    step(2);
    chk("t6_busy_fall", dl_busy, 1'b1);
    base    = ack_cnt;
    ack_dly = 2;
    ack_en  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!dl_busy) break;
    end
    chk("t6_acks", ack_cnt - base, 3);
    chk("t6_req_end", sdram_req, 1'b0);
    chk("t6_busy_end", dl_busy, 1'b0);
    chk("t6_ovf", overflow, 1'b0);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
